// File: rtl/onehot4_addsub_pipe_if.sv
// Handshake and data bundle for onehot4_addsub_pipe.
//   in_valid/in_ready   : operand beat handshake (a, b, sub, carry_in)
//   out_valid/out_ready : result handshake (sum, carry_out, err)
// Operands and result are base-4 one-hot digits, digit 0 in bits [3:0].
// master = the side that supplies operands and accepts results; slave = the adder.
interface onehot4_addsub_pipe_if #(
  parameter int unsigned DIGITS = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  sub;
  logic                  carry_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   sum;
  logic                  carry_out;
  logic                  err;

  modport master (
    output in_valid, a, b, sub, carry_in, out_ready,
    input  in_ready, out_valid, sum, carry_out, err
  );

  modport slave (
    input  in_valid, a, b, sub, carry_in, out_ready,
    output in_ready, out_valid, sum, carry_out, err
  );
endinterface

// File: rtl/onehot4_addsub_pipe.sv
// Pipelined base-4 one-hot adder/subtractor.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, discards all in-flight beats
//   bus : onehot4_addsub_pipe_if slave
//         in_valid/in_ready, a, b, sub, carry_in  -> operand beat
//         out_valid/out_ready, sum, carry_out, err -> result beat
// STAGES = ceil(DIGITS/SEG) register stages; stage s resolves SEG digits
// using the carry registered by stage s-1. The last stage is the output
// register, so a beat accepted at edge N is presented after edge N+STAGES-1.
// Subtract is A + (3-B per digit) + ~borrow_in; carry_out=1 means no borrow.
module onehot4_addsub_pipe #(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned SEG    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  onehot4_addsub_pipe_if.slave bus
);
  localparam int unsigned W      = 4 * DIGITS;
  localparam int unsigned STAGES = (DIGITS + SEG - 1) / SEG;
  localparam logic [W-1:0] ZERO_SUM = {DIGITS{4'b0001}};

  // Per-stage registers: skewed operands, partially resolved sum,
  // ripple carry between stages, sticky encoding error, and valid.
  logic [W-1:0] a_q [STAGES];
  logic [W-1:0] b_q [STAGES];
  logic [W-1:0] s_q [STAGES];
  logic         c_q [STAGES];
  logic         e_q [STAGES];
  logic         v_q [STAGES];

  // Inputs to each stage (stage 0 from the bus, others from stage s-1).
  logic [W-1:0] src_a [STAGES];
  logic [W-1:0] src_b [STAGES];
  logic [W-1:0] src_s [STAGES];
  logic         src_c [STAGES];
  logic         src_e [STAGES];
  logic         src_v [STAGES];

  // Next-state values of each stage register.
  logic [W-1:0] n_s [STAGES];
  logic         n_c [STAGES];
  logic         n_e [STAGES];

  logic [W-1:0] b_eff;
  logic         cin_eff;
  logic         err0;
  logic         adv;
  logic [W-1:0] ts;
  logic         tc;
  logic [2:0]   dsum;

  function automatic logic [1:0] oh2bin(input logic [3:0] g);
    return {g[3] | g[2], g[3] | g[1]};
  endfunction

  assign adv          = !v_q[STAGES-1] || bus.out_ready;
  assign bus.in_ready = adv;

  // Stage-0 operand conditioning: bit-reversing a group maps digit d to 3-d.
  always_comb begin
    b_eff   = bus.b;
    err0    = 1'b0;
    cin_eff = bus.sub ? ~bus.carry_in : bus.carry_in;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (bus.sub)
        b_eff[4*d +: 4] = {bus.b[4*d], bus.b[4*d+1], bus.b[4*d+2], bus.b[4*d+3]};
      if ($countones(bus.a[4*d +: 4]) != 1 || $countones(bus.b[4*d +: 4]) != 1)
        err0 = 1'b1;
    end
  end

  always_comb begin
    src_a[0] = bus.a;
    src_b[0] = b_eff;
    src_s[0] = ZERO_SUM;
    src_c[0] = cin_eff;
    src_e[0] = err0;
    src_v[0] = bus.in_valid;
    for (int unsigned s = 1; s < STAGES; s++) begin
      src_a[s] = a_q[s-1];
      src_b[s] = b_q[s-1];
      src_s[s] = s_q[s-1];
      src_c[s] = c_q[s-1];
      src_e[s] = e_q[s-1];
      src_v[s] = v_q[s-1];
    end
  end

  always_comb begin
    ts   = '0;
    tc   = 1'b0;
    dsum = '0;
    for (int unsigned s = 0; s < STAGES; s++) begin
      ts = src_s[s];
      tc = src_c[s];
      for (int unsigned d = s * SEG; d < (s + 1) * SEG && d < DIGITS; d++) begin
        dsum = {1'b0, oh2bin(src_a[s][4*d +: 4])} +
               {1'b0, oh2bin(src_b[s][4*d +: 4])} + {2'b00, tc};
        ts[4*d +: 4] = 4'b0001 << dsum[1:0];
        tc           = dsum[2];
      end
      // Errored beats leave the output register as value 0 with no carry.
      if (s == STAGES - 1 && src_e[s]) begin
        ts = ZERO_SUM;
        tc = 1'b0;
      end
      n_s[s] = ts;
      n_c[s] = tc;
      n_e[s] = src_e[s];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        a_q[s] <= '0;
        b_q[s] <= '0;
        s_q[s] <= ZERO_SUM;
        c_q[s] <= 1'b0;
        e_q[s] <= 1'b0;
        v_q[s] <= 1'b0;
      end
    end else if (adv) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        a_q[s] <= src_a[s];
        b_q[s] <= src_b[s];
        s_q[s] <= n_s[s];
        c_q[s] <= n_c[s];
        e_q[s] <= n_e[s];
        v_q[s] <= src_v[s];
      end
    end
  end

  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = s_q[STAGES-1];
  assign bus.carry_out = c_q[STAGES-1];
  assign bus.err       = e_q[STAGES-1];
endmodule

// File: tb/tb_onehot4_addsub_pipe.sv
// Self-checking bench for onehot4_addsub_pipe (DIGITS=8, SEG=2, latency 4).
module tb_onehot4_addsub_pipe;
  localparam int unsigned DIGITS = 8;
  localparam int unsigned LAT    = 4;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        err;
    int          t_acc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] exp_sum;
    logic        exp_cout;
    logic        exp_err;
  } vec_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  int   cyc;
  logic lat_chk;
  exp_t q[$];

  onehot4_addsub_pipe_if #(.DIGITS(DIGITS)) bus ();

  onehot4_addsub_pipe #(.DIGITS(DIGITS), .SEG(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: decode to binary, do plain integer arithmetic, re-encode.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic cin);
    exp_t        e;
    longint      av, bv, r;
    bit          bad;
    logic [31:0] wa, wb;
    av = 0; bv = 0; bad = 0; wa = a; wb = b;
    for (int d = 0; d < DIGITS; d++) begin
      if ($countones(wa[4*d +: 4]) != 1 || $countones(wb[4*d +: 4]) != 1) bad = 1;
      for (int k = 0; k < 4; k++) begin
        if (wa[4*d + k]) av += longint'(k) << (2 * d);
        if (wb[4*d + k]) bv += longint'(k) << (2 * d);
      end
    end
    e.t_acc = 0;
    if (bad) begin
      e.sum = 32'h11111111; e.cout = 1'b0; e.err = 1'b1;
    end else begin
      if (!sub) r = av + bv + longint'(cin);
      else      r = av - bv - longint'(cin) + 65536;
      e.cout = (r >= 65536);
      r      = r % 65536;
      e.err  = 1'b0;
      e.sum  = '0;
      for (int d = 0; d < DIGITS; d++)
        e.sum[4*d +: 4] = 4'b0001 << ((r >> (2 * d)) & 3);
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_oh();
    logic [31:0] v;
    v = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if ($urandom_range(0, 15) == 0) v[4*d +: 4] = 4'($urandom_range(0, 15));
      else                            v[4*d +: 4] = 4'b0001 << $urandom_range(0, 3);
    end
    return v;
  endfunction

  // One cycle: drive after the falling edge, then sample and score the
  // handshakes that the next rising edge will complete.
  task automatic step(input logic iv, input logic [31:0] ta, input logic [31:0] tbv,
                      input logic ts, input logic tc, input logic ordy,
                      input exp_t e, output logic acc);
    exp_t f;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.a         = ta;
    bus.b         = tbv;
    bus.sub       = ts;
    bus.carry_in  = tc;
    bus.out_ready = ordy;
    #1;
    cyc++;
    if (ordy) chk("in_ready_when_out_ready", {31'b0, bus.in_ready}, 32'd1);
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", {31'b0, bus.out_valid}, 32'd0);
      end else begin
        f = q.pop_front();
        chk("sum", bus.sum, f.sum);
        chk("carry_out", {31'b0, bus.carry_out}, {31'b0, f.cout});
        chk("err", {31'b0, bus.err}, {31'b0, f.err});
        if (lat_chk) chk("latency", cyc - f.t_acc, LAT);
      end
    end
    acc = iv && bus.in_ready;
    if (acc) begin
      f = e;
      f.t_acc = cyc;
      q.push_back(f);
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    exp_t z;
    z = model('0, '0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, z, acc);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (q.size() > 0 && i < 40) begin
      idle(1);
      i++;
    end
    chk("drain_queue_empty", q.size(), 0);
  endtask

  vec_t        vecs[8];
  logic [31:0] ra[6], rb[6];
  logic        rs[6], rc[6];
  logic        acc;
  logic        iv, ordy, s1, c1;
  logic [31:0] a1, b1;
  exp_t        ex;
  int          sent, t;

  initial begin
    vecs[0] = '{32'h11111118, 32'h11111112, 1'b0, 1'b0, 32'h11111121, 1'b0, 1'b0};
    vecs[1] = '{32'h88888888, 32'h11111111, 1'b0, 1'b1, 32'h11111111, 1'b1, 1'b0};
    vecs[2] = '{32'h11111111, 32'h11111112, 1'b1, 1'b0, 32'h88888888, 1'b0, 1'b0};
    vecs[3] = '{32'h11111122, 32'h11111118, 1'b1, 1'b0, 32'h11111114, 1'b1, 1'b0};
    vecs[4] = '{32'h11111113, 32'h11111111, 1'b0, 1'b0, 32'h11111111, 1'b0, 1'b1};
    vecs[5] = '{32'h11111128, 32'h11111112, 1'b0, 1'b0, 32'h11111141, 1'b0, 1'b0};
    vecs[6] = '{32'h11111122, 32'h11111112, 1'b1, 1'b1, 32'h11111118, 1'b1, 1'b0};
    vecs[7] = '{32'h11111111, 32'h01111111, 1'b0, 1'b0, 32'h11111111, 1'b0, 1'b1};

    n_chk = 0; n_fail = 0; cyc = 0; lat_chk = 1'b1;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0;
    bus.carry_in = 1'b0; bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_sum", bus.sum, 32'h11111111);
    chk("rst_carry_out", {31'b0, bus.carry_out}, 32'd0);
    chk("rst_err", {31'b0, bus.err}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    chk("idle_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("idle_sum", bus.sum, 32'h11111111);

    // Directed table, one beat at a time, exact latency checked
    for (int i = 0; i < 8; i++) begin
      ex.sum = vecs[i].exp_sum; ex.cout = vecs[i].exp_cout;
      ex.err = vecs[i].exp_err; ex.t_acc = 0;
      step(1'b1, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, 1'b1, ex, acc);
      chk("table_accept", {31'b0, acc}, 32'd1);
      drain();
    end

    // Directed table back-to-back: full throughput, still exact latency
    for (int i = 0; i < 8; i++) begin
      ex.sum = vecs[i].exp_sum; ex.cout = vecs[i].exp_cout;
      ex.err = vecs[i].exp_err; ex.t_acc = 0;
      step(1'b1, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, 1'b1, ex, acc);
      chk("b2b_accept", {31'b0, acc}, 32'd1);
    end
    drain();

    // Six back-to-back random beats with a three-cycle output stall
    lat_chk = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ra[i] = rand_oh(); rb[i] = rand_oh();
      rs[i] = 1'($urandom_range(0, 1)); rc[i] = 1'($urandom_range(0, 1));
    end
    sent = 0; t = 0;
    while (sent < 6 && t < 40) begin
      ordy = !(t >= 4 && t < 7);
      step(1'b1, ra[sent], rb[sent], rs[sent], rc[sent], ordy,
           model(ra[sent], rb[sent], rs[sent], rc[sent]), acc);
      if (!ordy) chk("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
      if (acc) sent++;
      t++;
    end
    chk("stall_beats_sent", sent, 6);
    drain();

    // Mid-stream reset: in-flight beats must vanish
    for (int i = 0; i < 6; i++) begin
      a1 = rand_oh(); b1 = rand_oh();
      step(1'b1, a1, b1, 1'b0, 1'b0, 1'b1, model(a1, b1, 1'b0, 1'b0), acc);
    end
    chk("pre_reset_out_valid", {31'b0, bus.out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("async_rst_sum", bus.sum, 32'h11111111);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      chk("post_rst_no_beat", {31'b0, bus.out_valid}, 32'd0);
    end

    // Random traffic with bubbles and stalls against the reference model
    for (int i = 0; i < 300; i++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 4) != 0);
      a1 = rand_oh(); b1 = rand_oh();
      s1 = 1'($urandom_range(0, 1)); c1 = 1'($urandom_range(0, 1));
      step(iv, a1, b1, s1, c1, ordy, model(a1, b1, s1, c1), acc);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
